// File: rtl/demux_32bits_4saidas.sv
// rtl/demux_32bits_4saidas.sv - registered 1-to-4 demux with single-entry buffer and valid/ready per output
module demux_32bits_4saidas #(
    parameter int LARGURA      = 32,
    parameter int LARGURA_CONT = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [LARGURA-1:0]      entrada,
    input  logic [1:0]              key,
    input  logic                    valid_entrada,
    output logic                    pronto_entrada,
    output logic [LARGURA-1:0]      saida1,
    output logic [LARGURA-1:0]      saida2,
    output logic [LARGURA-1:0]      saida3,
    output logic [LARGURA-1:0]      saida4,
    output logic                    valid_saida1,
    output logic                    valid_saida2,
    output logic                    valid_saida3,
    output logic                    valid_saida4,
    input  logic                    pronto_saida1,
    input  logic                    pronto_saida2,
    input  logic                    pronto_saida3,
    input  logic                    pronto_saida4,
    output logic [LARGURA_CONT-1:0] contador
);

    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_e;

    estado_e                 estado_q [4];
    estado_e                 estado_d [4];
    logic [LARGURA-1:0]      dado_q   [4];
    logic [LARGURA-1:0]      dado_d   [4];
    logic [LARGURA_CONT-1:0] cont_q;
    logic [LARGURA_CONT-1:0] cont_d;

    logic [3:0] cheio;
    logic [3:0] pronto_v;
    logic [3:0] dreno;
    logic [3:0] aceita_ch;
    logic       aceita;

    // Flatten per-channel state into vectors so the handshake can be indexed by key
    always_comb begin
        cheio = '0;
        for (int i = 0; i < 4; i++) begin
            cheio[i] = (estado_q[i] == CHEIO);
        end
    end

    assign pronto_v = {pronto_saida4, pronto_saida3, pronto_saida2, pronto_saida1};
    assign dreno    = cheio & pronto_v;

    // A full buffer can still take a new word if its consumer is draining it this cycle
    assign pronto_entrada = !cheio[key] || pronto_v[key];
    assign aceita         = valid_entrada && pronto_entrada;

    // One-hot of the channel receiving a word this cycle
    always_comb begin
        aceita_ch = '0;
        if (aceita) begin
            aceita_ch[key] = 1'b1;
        end
    end

    // Per-channel EMPTY/FULL next state, buffer load and accepted-word counter
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            estado_d[i] = estado_q[i];
            dado_d[i]   = dado_q[i];
            case (estado_q[i])
                VAZIO: begin
                    if (aceita_ch[i]) begin
                        estado_d[i] = CHEIO;
                        dado_d[i]   = entrada;
                    end
                end
                CHEIO: begin
                    // Accept while full only happens together with a drain: replace, stay full
                    if (aceita_ch[i]) begin
                        dado_d[i] = entrada;
                    end else if (dreno[i]) begin
                        estado_d[i] = VAZIO;
                    end
                end
                default: begin
                    estado_d[i] = VAZIO;
                end
            endcase
        end
        cont_d = cont_q + {{(LARGURA_CONT-1){1'b0}}, aceita};
    end

    // State registers; reset discards any buffered words immediately
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                estado_q[i] <= VAZIO;
                dado_q[i]   <= '0;
            end
            cont_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                estado_q[i] <= estado_d[i];
                dado_q[i]   <= dado_d[i];
            end
            cont_q <= cont_d;
        end
    end

    assign saida1       = dado_q[0];
    assign saida2       = dado_q[1];
    assign saida3       = dado_q[2];
    assign saida4       = dado_q[3];
    assign valid_saida1 = cheio[0];
    assign valid_saida2 = cheio[1];
    assign valid_saida3 = cheio[2];
    assign valid_saida4 = cheio[3];
    assign contador     = cont_q;

endmodule
